// File: rtl/x2c_bcnt_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : x2c_bcnt_rd_ctrl
// Brief    : Read-side sequencer for the LMAC TX byte-count and data FIFOs.
//            Pops one byte-count word, then reads that packet's 64-bit words
//            and presents them as a valid/ready beat stream with SOP/EOP/BE.
//            Flagged or malformed packets are read out and discarded so the
//            two FIFOs stay aligned.
// Revision : 1.0 - initial release
// ============================================================================
module x2c_bcnt_rd_ctrl #(
  parameter int DWIDTH   = 64,
  parameter int BCW      = 16,
  parameter int MAX_BCNT = 9600
) (
  input  logic                  rdclk,
  input  logic                  aclr,
  input  logic                  bc_empty,
  output logic                  bc_rdreq,
  input  logic [31:0]           bc_q,
  input  logic                  d_empty,
  output logic                  d_rdreq,
  input  logic [DWIDTH-1:0]     d_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DWIDTH-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DWIDTH/8-1:0]   out_be,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  err,
  output logic                  busy
);

  localparam int c_BEW = DWIDTH / 8;
  localparam int c_WW  = BCW - 2;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_BCWAIT  = 2'd1;
  localparam logic [1:0] c_ST_DATA    = 2'd2;
  localparam logic [1:0] c_ST_DISCARD = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_WW-1:0]   r_words_left;
  logic [c_BEW-1:0]  r_last_be;
  logic              r_first;

  // read issued last cycle whose data lands in the output buffer this cycle
  logic              r_infl;
  logic              r_infl_sop;
  logic              r_infl_eop;
  logic [c_BEW-1:0]  r_infl_be;

  // 2-entry output buffer
  logic [DWIDTH-1:0] r_buf_data [2];
  logic [c_BEW-1:0]  r_buf_be   [2];
  logic [1:0]        r_buf_sop;
  logic [1:0]        r_buf_eop;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;

  logic [31:0]       r_pkt_cnt;
  logic [15:0]       r_drop_cnt;
  logic              r_err;

  logic [BCW-1:0]    w_bcnt;
  logic [c_WW-1:0]   w_words;
  logic [c_BEW-1:0]  w_last_be;
  logic              w_drop;
  logic              w_unused_bc;
  logic              w_pop;
  logic              w_room;
  logic              w_last;
  logic              w_bc_rd;
  logic              w_d_rd;
  logic              w_fwd_rd;
  logic              w_fin_pkt;
  logic              w_fin_drop;

  // Byte-count word decode, meaningful while in BCWAIT
  assign w_bcnt      = bc_q[BCW-1:0];
  assign w_words     = c_WW'((32'(w_bcnt) + 32'd7) >> 3);
  assign w_last_be   = (w_bcnt[2:0] == 3'd0) ? '1 : c_BEW'((32'd1 << w_bcnt[2:0]) - 32'd1);
  assign w_drop      = bc_q[31] | (w_bcnt == '0) | (32'(w_bcnt) > 32'(MAX_BCNT));
  assign w_unused_bc = ^bc_q[30:BCW];

  // A forwarded read is allowed only if the buffer can absorb it even when
  // downstream stalls: occupancy plus in-flight, after this cycle's pop, <= 1.
  assign w_pop  = (r_occ != 2'd0) & out_ready;
  assign w_room = (({1'b0, r_occ} + {2'b0, r_infl}) - {2'b0, w_pop}) <= 3'd1;
  assign w_last = (r_words_left == c_WW'(1));

  // State register
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) r_state <= c_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_bc_rd) w_state_nxt = c_ST_BCWAIT;
      c_ST_BCWAIT: begin
        if (w_drop && (w_words == '0)) w_state_nxt = c_ST_IDLE;
        else if (w_drop)               w_state_nxt = c_ST_DISCARD;
        else                           w_state_nxt = c_ST_DATA;
      end
      c_ST_DATA,
      c_ST_DISCARD: if (w_d_rd && w_last) w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FIFO read requests decoded from the current state
  always_comb begin
    w_bc_rd = 1'b0;
    w_d_rd  = 1'b0;
    case (r_state)
      c_ST_IDLE:    w_bc_rd = ~bc_empty;
      c_ST_DATA:    w_d_rd  = ~d_empty & (r_words_left != '0) & w_room;
      c_ST_DISCARD: w_d_rd  = ~d_empty & (r_words_left != '0);
      default:      w_bc_rd = 1'b0;
    endcase
  end

  // Reset forces the requests low in the same cycle, not just after the edge
  assign bc_rdreq = w_bc_rd & ~aclr;
  assign d_rdreq  = w_d_rd & ~aclr;

  assign w_fwd_rd   = (r_state == c_ST_DATA) & w_d_rd;
  assign w_fin_pkt  = w_fwd_rd & w_last;
  assign w_fin_drop = ((r_state == c_ST_DISCARD) & w_d_rd & w_last) |
                      ((r_state == c_ST_BCWAIT) & w_drop & (w_words == '0));

  // Packet bookkeeping, in-flight tagging and counters
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      r_words_left <= '0;
      r_last_be    <= '0;
      r_first      <= 1'b0;
      r_infl       <= 1'b0;
      r_infl_sop   <= 1'b0;
      r_infl_eop   <= 1'b0;
      r_infl_be    <= '0;
      r_pkt_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (r_state == c_ST_BCWAIT) begin
        r_words_left <= w_words;
        r_last_be    <= w_last_be;
        r_first      <= 1'b1;
      end else if (w_d_rd) begin
        r_words_left <= r_words_left - c_WW'(1);
        r_first      <= 1'b0;
      end
      r_infl <= w_fwd_rd;
      if (w_fwd_rd) begin
        r_infl_sop <= r_first;
        r_infl_eop <= w_last;
        r_infl_be  <= w_last ? r_last_be : '1;
      end
      r_err <= w_fin_drop;
      if (w_fin_pkt)
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_fin_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Output buffer: write returned data, pop on handshake, order preserved
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_be[0]   <= '0;
      r_buf_be[1]   <= '0;
      r_buf_sop     <= '0;
      r_buf_eop     <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_occ         <= '0;
    end else begin
      if (r_infl) begin
        r_buf_data[r_wptr] <= d_q;
        r_buf_be[r_wptr]   <= r_infl_be;
        r_buf_sop[r_wptr]  <= r_infl_sop;
        r_buf_eop[r_wptr]  <= r_infl_eop;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
    end
  end

  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_buf_data[r_rptr];
  assign out_be    = r_buf_be[r_rptr];
  assign out_sop   = r_buf_sop[r_rptr];
  assign out_eop   = r_buf_eop[r_rptr];
  assign pkt_cnt   = r_pkt_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign err       = r_err;
  assign busy      = (r_state != c_ST_IDLE) | (r_occ != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_x2c_bcnt_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_x2c_bcnt_rd_ctrl
// Brief    : Self-checking bench for x2c_bcnt_rd_ctrl. Models both FIFOs as
//            queues and predicts the beat stream from the packet rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x2c_bcnt_rd_ctrl;

  logic        rdclk = 1'b0;
  logic        aclr;
  logic        bc_empty;
  logic        bc_rdreq;
  logic [31:0] bc_q;
  logic        d_empty;
  logic        d_rdreq;
  logic [63:0] d_q;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  out_be;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        err;
  logic        busy;

  x2c_bcnt_rd_ctrl #(.DWIDTH(64), .BCW(16), .MAX_BCNT(9600)) dut (
    .rdclk(rdclk), .aclr(aclr),
    .bc_empty(bc_empty), .bc_rdreq(bc_rdreq), .bc_q(bc_q),
    .d_empty(d_empty), .d_rdreq(d_rdreq), .d_q(d_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_be(out_be),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err(err), .busy(busy)
  );

  always #5 rdclk = ~rdclk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [7:0]  be;
    logic [63:0] data;
  } beat_t;

  logic [31:0] bcq[$];
  logic [63:0] dq[$];
  bit          dkeep[$];
  beat_t       expq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_pkts = 0, exp_drops = 0, err_seen = 0;
  int rd_seen = 0, ov_seen = 0, outstanding = 0;
  int first_bc_cyc = -1, first_ov_cyc = -1;
  int rd_cycles[$];
  bit rnd_ready = 0, rnd_gap = 0;
  bit stalled_prev = 0;
  logic [74:0] held;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(string tag);
    check(tag, {bc_rdreq, d_rdreq, out_valid, out_data, out_sop, out_eop,
                out_be, pkt_cnt, drop_cnt, err, busy}, '0);
  endtask

  // Queue one packet into the FIFO models and predict its outcome
  task automatic push_pkt(int bcnt, bit flag);
    int  words;
    bit  keep;
    words = (bcnt + 7) / 8;
    keep  = !flag && (bcnt != 0) && (bcnt <= 9600);
    bcq.push_back({flag, 15'd0, 16'(bcnt)});
    for (int i = 0; i < words; i++) begin
      logic [63:0] w;
      beat_t b;
      w = {$urandom, $urandom};
      dq.push_back(w);
      dkeep.push_back(keep);
      if (keep) begin
        b.data = w;
        b.sop  = (i == 0);
        b.eop  = (i == words - 1);
        b.be   = (b.eop && (bcnt % 8 != 0)) ? 8'((1 << (bcnt % 8)) - 1) : 8'hFF;
        expq.push_back(b);
      end
    end
    if (keep) exp_pkts++;
    else      exp_drops++;
    bc_empty = (bcq.size() == 0);
    d_empty  = (dq.size() == 0);
  endtask

  // One clock cycle: sample and check at negedge, drive FIFO/ready after posedge
  task automatic step();
    bit          take_bc, take_d;
    logic [31:0] nxt_bc;
    logic [63:0] nxt_d;
    beat_t       b;
    take_bc = 0;
    take_d  = 0;
    nxt_bc  = bc_q;
    nxt_d   = d_q;
    @(negedge rdclk);
    if (bc_empty) check("bc_rdreq_while_empty", bc_rdreq, 0);
    if (d_empty)  check("d_rdreq_while_empty", d_rdreq, 0);
    if (stalled_prev)
      check("stall_hold", {out_valid, out_sop, out_eop, out_be, out_data}, held);
    if (err)       err_seen++;
    if (out_valid) ov_seen++;
    if (bc_rdreq && first_bc_cyc < 0) first_bc_cyc = cyc;
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (out_valid && out_ready) begin
      outstanding--;
      if (expq.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        b = expq.pop_front();
        check("beat", {out_sop, out_eop, out_be, out_data}, b);
      end
    end
    if (bc_rdreq && bcq.size() > 0) begin
      take_bc = 1;
      nxt_bc  = bcq.pop_front();
    end
    if (d_rdreq) begin
      rd_seen++;
      rd_cycles.push_back(cyc);
      if (dq.size() > 0) begin
        take_d = 1;
        nxt_d  = dq.pop_front();
        if (dkeep.pop_front()) begin
          outstanding++;
          check("outstanding_le_2", outstanding <= 2, 1);
        end
      end
    end
    stalled_prev = out_valid && !out_ready;
    held = {out_valid, out_sop, out_eop, out_be, out_data};
    @(posedge rdclk);
    #1;
    cyc++;
    if (take_bc) bc_q = nxt_bc;
    if (take_d)  d_q  = nxt_d;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bc_empty  = (bcq.size() == 0);
    d_empty   = (dq.size() == 0) || (rnd_gap && ($urandom_range(0, 2) == 0));
  endtask

  task automatic drain(int max);
    int n;
    n = 0;
    while (!(bcq.size() == 0 && dq.size() == 0 && expq.size() == 0 && !busy) && n < max) begin
      step();
      n++;
    end
    if (n >= max) check("drain_timeout", 1, 0);
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr      = 1'b1;
    bc_empty  = 1'b1;
    d_empty   = 1'b1;
    bc_q      = '0;
    d_q       = '0;
    out_ready = 1'b1;
    #1;
    check_zero("reset_outputs");
    step();
    step();
    aclr = 1'b0;

    // 64-byte packet: 8 full beats, latency bc_rdreq -> out_valid = 4
    first_bc_cyc = -1;
    first_ov_cyc = -1;
    ov_seen = 0;
    push_pkt(64, 0);
    drain(200);
    check("latency_bc_to_valid", first_ov_cyc - first_bc_cyc, 4);
    check("beats_64", ov_seen, 8);
    check("pkt_cnt_1", pkt_cnt, exp_pkts);

    // Partial last word and single-byte packet
    push_pkt(61, 0);
    drain(200);
    push_pkt(1, 0);
    drain(200);
    check("pkt_cnt_3", pkt_cnt, exp_pkts);

    // Flagged 100-byte packet is read out (13 words) and dropped
    rd_seen = 0;
    ov_seen = 0;
    err_seen = 0;
    push_pkt(100, 1);
    drain(200);
    check("discard_reads", rd_seen, 13);
    check("discard_no_valid", ov_seen, 0);
    check("discard_err", err_seen, 1);
    check("drop_cnt_1", drop_cnt, exp_drops);

    // Zero-length: dropped without any data read
    rd_seen = 0;
    push_pkt(0, 0);
    drain(200);
    check("zero_no_reads", rd_seen, 0);
    check("drop_cnt_2", drop_cnt, exp_drops);

    // Oversized: read out and dropped
    rd_seen = 0;
    ov_seen = 0;
    push_pkt(9601, 0);
    drain(3000);
    check("oversize_reads", rd_seen, 1201);
    check("oversize_no_valid", ov_seen, 0);
    check("err_pulses", err_seen, 3);
    check("drop_cnt_3", drop_cnt, exp_drops);

    // Random backpressure and FIFO gaps across 20 packets
    rnd_ready = 1;
    rnd_gap   = 1;
    err_seen  = 0;
    begin
      int d0;
      d0 = exp_drops;
      for (int p = 0; p < 20; p++)
        push_pkt($urandom_range(1, 200), $urandom_range(0, 4) == 0);
      drain(20000);
      check("rand_err_pulses", err_seen, exp_drops - d0);
    end
    rnd_ready = 0;
    rnd_gap   = 0;
    step();
    check("rand_pkt_cnt", pkt_cnt, exp_pkts);
    check("rand_drop_cnt", drop_cnt, exp_drops);

    // Back-to-back 16 and 24 byte packets: 2-cycle d_rdreq gap
    rd_cycles.delete();
    push_pkt(16, 0);
    push_pkt(24, 0);
    drain(200);
    check("b2b_reads", rd_cycles.size(), 5);
    if (rd_cycles.size() == 5) begin
      check("b2b_burst1", rd_cycles[1] - rd_cycles[0], 1);
      check("b2b_gap", rd_cycles[2] - rd_cycles[1], 3);
      check("b2b_burst2", rd_cycles[4] - rd_cycles[2], 2);
    end
    check("b2b_pkt_cnt", pkt_cnt, exp_pkts);

    // Reset in the middle of a 64-byte packet
    push_pkt(64, 0);
    for (int i = 0; i < 7; i++) step();
    check("mid_pkt_valid", out_valid, 1);
    push_pkt(32, 0);
    bc_empty = 1'b0;
    d_empty  = 1'b0;
    aclr     = 1'b1;
    #1;
    check_zero("mid_reset_outputs");
    bcq.delete();
    dq.delete();
    dkeep.delete();
    expq.delete();
    outstanding  = 0;
    exp_pkts     = 0;
    exp_drops    = 0;
    err_seen     = 0;
    stalled_prev = 0;
    bc_empty     = 1'b1;
    d_empty      = 1'b1;
    step();
    step();
    aclr = 1'b0;
    push_pkt(8, 0);
    drain(200);
    check("post_reset_pkt_cnt", pkt_cnt, 1);
    check("post_reset_drop_cnt", drop_cnt, 0);
    check("post_reset_err", err_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x2c_bcnt_rd_ctrl.md
# x2c_bcnt_rd_ctrl

Read-side sequencer for the transmit byte-count and packet-data FIFOs in the LMAC transmit path. The block pops one byte-count word from the 256x32 byte-count FIFO and then reads exactly that packet's 64-bit words from the data FIFO. It presents each packet downstream as a valid/ready beat stream with SOP, EOP and last-beat byte enables. Flagged or malformed packets are read out and discarded, so the two FIFOs always stay aligned.

## Interface
- DWIDTH, 64, data FIFO / output word width (8 bytes per word)
- BCW, 16, byte-count field width, taken from bc_q[BCW-1:0]
- MAX_BCNT, 9600, largest legal byte count
- rdclk  in  1  single clock (read domain of both FIFOs)
- aclr  in  1  reset, asynchronous, active-high
- bc_empty  in  1  byte-count FIFO empty
- bc_rdreq  out  1  byte-count FIFO read request
- bc_q  in  32  byte-count word: [BCW-1:0] byte count, [31] drop flag, the rest ignored
- d_empty  in  1  data FIFO empty
- d_rdreq  out  1  data FIFO read request
- d_q  in  DWIDTH  data FIFO output
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  DWIDTH  beat data; byte 0 is in [7:0]
- out_sop  out  1  first beat of a packet
- out_eop  out  1  last beat of a packet
- out_be  out  DWIDTH/8  byte enables; all ones except on the EOP beat
- pkt_cnt  out  32  packets forwarded (wraps)
- drop_cnt  out  16  packets discarded (saturates at 16'hFFFF)
- err  out  1  one-cycle pulse on each discard
- busy  out  1  state is not IDLE, or the output buffer is not empty

## Operation
- Both FIFOs are non-showahead: q is valid in the cycle after rdreq.
- **IDLE:** when bc_empty=0, assert bc_rdreq for one cycle and go to BCWAIT.
- **BCWAIT:** capture bc_q.
  - words = (bcnt+7)>>3, with width BCW-2.
  - last_be: all ones if bcnt[2:0]==0, else (1<<bcnt[2:0])-1.
  - drop = bc_q[31] | (bcnt==0) | (bcnt>MAX_BCNT).
  - If drop and words==0: pulse err, increment drop_cnt, go to IDLE.
  - Else if drop: go to DISCARD.
  - Else: go to DATA.
- **DATA:**
  - Issue d_rdreq when all three hold: d_empty=0, words_left>0, and occ+infl-pop <= 1.
    - occ = occupancy of the 2-entry output buffer.
    - infl = read issued in the previous cycle.
    - pop = out_valid & out_ready.
  - Each returned d_q is written into the buffer together with sop (first word), eop (last word) and be (last_be on eop, else all ones).
  - After the last d_rdreq, increment pkt_cnt and go to IDLE.
- **DISCARD:**
  - Issue d_rdreq whenever d_empty=0 and words_left>0. Returned words are not written to the buffer.
  - After the last read, pulse err, increment drop_cnt and go to IDLE.
- Returning to IDLE does not wait for the output buffer to drain. The next packet's bc_rdreq may overlap the previous packet's outstanding beats.
- Output is taken from the head of the buffer. out_valid = occ>0.
- Outputs must hold stable while out_valid=1 and out_ready=0.
- d_rdreq is never asserted while d_empty=1. bc_rdreq is never asserted while bc_empty=1.
- Simultaneous buffer write and pop in one cycle: occ is unchanged and order is preserved.
- Counters: pkt_cnt wraps 2^32-1 to 0. drop_cnt saturates.

## Timing
- Reset (aclr=1): state IDLE, occ=0, infl=0.
  - All outputs 0: bc_rdreq, d_rdreq, out_valid, out_data, out_sop, out_eop, out_be, pkt_cnt, drop_cnt, err, busy.
  - Takes effect immediately. Any in-progress packet is abandoned; the FIFOs share the same aclr.
- Latency, with FIFOs non-empty and out_ready=1:
  - bc_rdreq in cycle 0.
  - BCWAIT in cycle 1.
  - First d_rdreq in cycle 2.
  - d_q returns in cycle 3.
  - First out_valid in cycle 4.
- Sustained rate is 1 beat/cycle within a packet. The gap between packets is 2 cycles of d_rdreq (IDLE + BCWAIT).
- With out_ready=0, at most 2 reads are ever outstanding, and the buffer never overflows.
- err, and the pkt_cnt/drop_cnt updates, are registered and appear one cycle after the terminating read decision.

## Test plan
- bcnt=64, flag 0: 8 beats; SOP on beat 0, EOP on beat 7; out_be=8'hFF throughout; pkt_cnt=1; first out_valid 4 cycles after bc_rdreq.
- bcnt=61: 8 beats; EOP beat out_be=8'h1F. bcnt=1: 1 beat with SOP=EOP=1 and out_be=8'h01.
- bc_q[31]=1, bcnt=100: exactly 13 d_rdreq pulses; out_valid stays 0; err pulses once; drop_cnt=1. bcnt=0 and bcnt=9601 are also discarded, and bcnt=0 causes no d_rdreq.
- Random out_ready (50%) and random d_empty gaps over 20 packets: data order and SOP/EOP are intact; no d_rdreq while d_empty; outputs stable while stalled; occ never exceeds 2.
- Back-to-back packets of 16 and 24 bytes with out_ready=1: 2 beats, then 3 beats; d_rdreq gap is exactly 2 cycles; pkt_cnt=2.
- aclr asserted in the middle of a 64-byte packet: all outputs are 0 the same cycle. After release, a new 8-byte packet is forwarded correctly.
